ship_lives_controller: RTL and testbench

- Tracks the player ship's lives during a Galaga round. Sits directly upstream of the game state controller and drives its `hit` input.
- Consumes raw ship collision from the collision logic, plus `play` and the VGA vertical sync.
- Sequences each ship loss through explosion, respawn invulnerability and final death.
- Exports lives count, visibility and control-enable flags to the ship sprite, ship motion and HUD blocks.

---
 rtl/ship_lives_controller.sv | 138 +++++++++++++
 tb/tb_ship_lives_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ship_lives_controller.sv
// Player ship lives sequencer: ALIVE -> EXPLODING -> RESPAWN/DEAD, frame-timed via VGA vsync.
// Optional build macro SHIP_EXTRA_LIFE_EN adds the extra_life input from the score logic.
module ship_lives_controller #(
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 30,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_SHIFT    = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play,
  input  logic       frame_sync,
  input  logic       collision,
`ifdef SHIP_EXTRA_LIFE_EN
  input  logic       extra_life,
`endif
  output logic       hit,
  output logic [2:0] lives,
  output logic       ship_visible,
  output logic       ship_active,
  output logic       exploding
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ALIVE     = 3'd1;
  localparam logic [2:0] EXPLODING = 3'd2;
  localparam logic [2:0] RESPAWN   = 3'd3;
  localparam logic [2:0] DEAD      = 3'd4;

  localparam logic [2:0] LIVES_INIT   = 3'(LIVES);
  localparam logic [7:0] EXPLODE_LAST = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST  = 8'(INVULN_FRAMES - 1);

  logic [2:0] state, state_d;
  logic [2:0] lives_d;
  logic [7:0] frame_cnt;
  logic       frame_sync_q;
  logic       frame_tick;
  logic       extra_inc;

`ifdef SHIP_EXTRA_LIFE_EN
  assign extra_inc = extra_life;
`else
  assign extra_inc = 1'b0;
`endif

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  assign frame_tick = frame_sync & ~frame_sync_q;

  always_comb begin
    state_d = state;
    lives_d = lives;
    case (state)
      IDLE: begin
        lives_d = LIVES_INIT;
        if (play) state_d = ALIVE;
      end
      ALIVE: begin
        if (collision) begin
          state_d = EXPLODING;
          // A simultaneous extra life cancels the loss.
          if (!extra_inc) lives_d = sat_dec(lives);
        end else if (extra_inc) begin
          lives_d = sat_inc(lives);
        end
      end
      EXPLODING: begin
        if (extra_inc) lives_d = sat_inc(lives);
        if (frame_tick && frame_cnt == EXPLODE_LAST)
          state_d = (lives_d == 3'd0) ? DEAD : RESPAWN;
      end
      RESPAWN: begin
        if (extra_inc) lives_d = sat_inc(lives);
        if (frame_tick && frame_cnt == INVULN_LAST) state_d = ALIVE;
      end
      DEAD: begin
        lives_d = 3'd0;
      end
      default: begin
        state_d = IDLE;
        lives_d = LIVES_INIT;
      end
    endcase
    // Leaving PLAY overrides everything, including a same-cycle collision.
    if (!play) begin
      state_d = IDLE;
      lives_d = LIVES_INIT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      lives        <= LIVES_INIT;
      frame_cnt    <= 8'd0;
      frame_sync_q <= 1'b1;
    end else begin
      state        <= state_d;
      lives        <= lives_d;
      frame_sync_q <= frame_sync;
      if (state_d != state)
        frame_cnt <= 8'd0;
      else if (frame_tick)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    hit          = 1'b0;
    ship_visible = 1'b0;
    ship_active  = 1'b0;
    exploding    = 1'b0;
    case (state)
      ALIVE: begin
        ship_visible = 1'b1;
        ship_active  = 1'b1;
      end
      EXPLODING: begin
        exploding    = 1'b1;
        ship_visible = 1'b1;
      end
      RESPAWN: begin
        ship_active  = 1'b1;
        ship_visible = frame_cnt[BLINK_SHIFT];
      end
      DEAD: hit = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ship_lives_controller.sv
// Directed bench for ship_lives_controller; covers SHIP_EXTRA_LIFE_EN steps when that macro is defined.
module tb_ship_lives_controller;

  logic       Clk = 1'b0;
  logic       Reset, play, frame_sync, collision;
  logic       hit, ship_visible, ship_active, exploding;
  logic [2:0] lives;
`ifdef SHIP_EXTRA_LIFE_EN
  logic       extra_life = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  ship_lives_controller dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .play         (play),
    .frame_sync   (frame_sync),
    .collision    (collision),
`ifdef SHIP_EXTRA_LIFE_EN
    .extra_life   (extra_life),
`endif
    .hit          (hit),
    .lives        (lives),
    .ship_visible (ship_visible),
    .ship_active  (ship_active),
    .exploding    (exploding)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One vsync rising edge: low for a cycle, then high; the tick is consumed on the second edge.
  task automatic tick();
    frame_sync = 1'b0;
    step();
    frame_sync = 1'b1;
    step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Flags packed as {hit, ship_visible, ship_active, exploding}.
  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk(tag, {4'd0, hit, ship_visible, ship_active, exploding}, {4'd0, exp});
  endtask

  task automatic lose_life(input logic [2:0] exp_after);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("loss_lives", {5'd0, lives}, {5'd0, exp_after});
    for (int i = 0; i < 30; i++) tick();
    for (int i = 0; i < 120; i++) tick();
    chk_flags("loss_back_alive", 4'b0110);
  endtask

  initial begin
    Reset = 1'b1; play = 1'b0; frame_sync = 1'b1; collision = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();
    chk_flags("reset_flags", 4'b0000);
    chk("reset_lives", {5'd0, lives}, 8'd3);

    play = 1'b1;
    step();
    chk_flags("alive_flags", 4'b0110);
    chk("alive_lives", {5'd0, lives}, 8'd3);

    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("hit1_lives", {5'd0, lives}, 8'd2);
    chk_flags("hit1_exploding", 4'b0101);

    for (int i = 0; i < 29; i++) tick();
    chk_flags("explode_29_ticks", 4'b0101);
    tick();
    chk_flags("respawn_entry", 4'b0010);

    collision = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk_flags("blink_7_off", 4'b0010);
    tick();
    chk_flags("blink_8_on", 4'b0110);
    chk("respawn_lives_hold", {5'd0, lives}, 8'd2);
    for (int i = 0; i < 8; i++) tick();
    chk_flags("blink_16_off", 4'b0010);
    for (int i = 0; i < 103; i++) tick();
    chk_flags("respawn_119_ticks", 4'b0010);
    tick();
    chk_flags("alive_after_120", 4'b0110);
    chk("edge_collision_ignored", {5'd0, lives}, 8'd2);
    step();
    collision = 1'b0;
    chk("hit2_lives", {5'd0, lives}, 8'd1);
    chk_flags("hit2_exploding", 4'b0101);

    for (int i = 0; i < 150; i++) tick();
    chk_flags("alive_before_hit3", 4'b0110);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("hit3_lives", {5'd0, lives}, 8'd0);
    for (int i = 0; i < 29; i++) tick();
    chk_flags("hit3_still_exploding", 4'b0101);
    tick();
    chk_flags("dead_flags", 4'b1000);
    chk("dead_lives", {5'd0, lives}, 8'd0);
    step(); step();
    chk_flags("dead_held", 4'b1000);

    play = 1'b0;
    step();
    chk_flags("idle_after_dead", 4'b0000);
    chk("idle_lives", {5'd0, lives}, 8'd3);
    play = 1'b1;
    step();
    chk_flags("replay_alive", 4'b0110);

    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("abort_explode_lives", {5'd0, lives}, 8'd2);
    for (int i = 0; i < 9; i++) tick();
    chk_flags("abort_mid_explode", 4'b0101);
    play = 1'b0;
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk_flags("abort_idle_flags", 4'b0000);
    chk("abort_idle_lives", {5'd0, lives}, 8'd3);

`ifdef SHIP_EXTRA_LIFE_EN
    play = 1'b1;
    step();
    lose_life(3'd2);
    lose_life(3'd1);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("xl_last_loss", {5'd0, lives}, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    extra_life = 1'b1;
    step();
    extra_life = 1'b0;
    chk("xl_pulse_lives", {5'd0, lives}, 8'd1);
    for (int i = 0; i < 25; i++) tick();
    chk_flags("xl_respawn_not_dead", 4'b0010);
    for (int i = 0; i < 120; i++) tick();
    chk_flags("xl_alive", 4'b0110);
    for (int i = 0; i < 8; i++) begin
      extra_life = 1'b1;
      step();
      extra_life = 1'b0;
      step();
    end
    chk("xl_saturate", {5'd0, lives}, 8'd7);
    extra_life = 1'b1;
    collision = 1'b1;
    step();
    extra_life = 1'b0;
    collision = 1'b0;
    chk("xl_cancel", {5'd0, lives}, 8'd7);
    chk_flags("xl_cancel_exploding", 4'b0101);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
